// File: rtl/serialize_ctrl.sv
// Sequencing controller for a WIDTH-bit parallel-in/serial-out shift register.
// Optional parity period and parity_bit output are built when SERIALIZE_CTRL_PARITY_EN is defined.
module serialize_ctrl #(
  parameter int WIDTH   = 4,
  parameter int CLK_DIV = 1
) (
  input  logic             input_input_switch1_clock_1,
  input  logic             input_input_switch2_reset_n_2,
  input  logic             start_valid,
  input  logic [WIDTH-1:0] start_data,
  output logic             start_ready,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_load_shift,
  output logic             sr_en,
  output logic             bit_valid,
  output logic [3:0]       bit_index,
  output logic             frame_done,
  output logic             busy
`ifdef SERIALIZE_CTRL_PARITY_EN
  ,
  output logic             parity_bit
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
`ifdef SERIALIZE_CTRL_PARITY_EN
    S_PARITY,
`endif
    S_DONE
  } state_t;

  localparam logic [3:0] BIT_LAST = 4'(WIDTH - 1);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state, next_state;
  logic [3:0] bit_cnt;
  logic [7:0] div_cnt;
  logic       div_last, bit_last;

  assign div_last = (div_cnt == DIV_LAST);
  assign bit_last = (bit_cnt == BIT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge input_input_switch1_clock_1 or negedge input_input_switch2_reset_n_2) begin
    if (!input_input_switch2_reset_n_2) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state    = state;
    start_ready   = 1'b0;
    sr_load_shift = 1'b0;
    sr_en         = 1'b0;
    bit_valid     = 1'b0;
    bit_index     = 4'd0;
    frame_done    = 1'b0;
`ifdef SERIALIZE_CTRL_PARITY_EN
    parity_bit    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) next_state = S_LOAD;
      end
      S_LOAD: begin
        sr_en      = 1'b1;
        next_state = S_SHIFT;
      end
      S_SHIFT: begin
        sr_load_shift = 1'b1;
        bit_valid     = 1'b1;
        bit_index     = bit_cnt;
        if (div_last) begin
          // The final bit is already on the line; shifting again would lose it.
          if (!bit_last) begin
            sr_en = 1'b1;
          end else begin
`ifdef SERIALIZE_CTRL_PARITY_EN
            next_state = S_PARITY;
`else
            next_state = S_DONE;
`endif
          end
        end
      end
`ifdef SERIALIZE_CTRL_PARITY_EN
      S_PARITY: begin
        bit_valid  = 1'b1;
        bit_index  = 4'(WIDTH);
        parity_bit = ^sr_data;
        if (div_last) next_state = S_DONE;
      end
`endif
      S_DONE: begin
        frame_done = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Divider paces each bit period; the bit counter advances on its last count.
  always_ff @(posedge input_input_switch1_clock_1 or negedge input_input_switch2_reset_n_2) begin
    if (!input_input_switch2_reset_n_2) begin
      bit_cnt <= 4'd0;
      div_cnt <= 8'd0;
    end else begin
      case (state)
        S_LOAD: begin
          bit_cnt <= 4'd0;
          div_cnt <= 8'd0;
        end
        S_SHIFT: begin
          if (div_last) begin
            div_cnt <= 8'd0;
            if (!bit_last) bit_cnt <= bit_cnt + 4'd1;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
`ifdef SERIALIZE_CTRL_PARITY_EN
        S_PARITY: begin
          div_cnt <= div_last ? 8'd0 : div_cnt + 8'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  // The word is captured only on a handshake in IDLE, so requests mid-frame are ignored.
  always_ff @(posedge input_input_switch1_clock_1 or negedge input_input_switch2_reset_n_2) begin
    if (!input_input_switch2_reset_n_2) begin
      sr_data <= '0;
    end else if (state == S_IDLE && start_valid) begin
      sr_data <= start_data;
    end
  end

endmodule

// File: tb/tb_serialize_ctrl.sv
// Self-checking bench for serialize_ctrl: two instances (CLK_DIV=1 and 3) share
// randomized stimulus and are compared cycle by cycle against a timeline model.
module tb_serialize_ctrl;

  localparam int W = 4;
`ifdef SERIALIZE_CTRL_PARITY_EN
  localparam int PEXT = 1;
`else
  localparam int PEXT = 0;
`endif

  typedef struct packed {
    logic       ready;
    logic       ld_sh;
    logic       en;
    logic       bv;
    logic [3:0] idx;
    logic       done;
    logic       busy;
    logic       par;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic [W-1:0] start_data = '0;

  logic         ready1, ld1, en1, bv1, done1, busy1, par1;
  logic [3:0]   idx1;
  logic [W-1:0] data1;
  logic         ready3, ld3, en3, bv3, done3, busy3, par3;
  logic [3:0]   idx3;
  logic [W-1:0] data3;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  serialize_ctrl #(.WIDTH(W), .CLK_DIV(1)) dut1 (
    .input_input_switch1_clock_1  (clk),
    .input_input_switch2_reset_n_2(rst_n),
    .start_valid  (start_valid),
    .start_data   (start_data),
    .start_ready  (ready1),
    .sr_data      (data1),
    .sr_load_shift(ld1),
    .sr_en        (en1),
    .bit_valid    (bv1),
    .bit_index    (idx1),
    .frame_done   (done1),
    .busy         (busy1)
`ifdef SERIALIZE_CTRL_PARITY_EN
    ,
    .parity_bit   (par1)
`endif
  );

  serialize_ctrl #(.WIDTH(W), .CLK_DIV(3)) dut3 (
    .input_input_switch1_clock_1  (clk),
    .input_input_switch2_reset_n_2(rst_n),
    .start_valid  (start_valid),
    .start_data   (start_data),
    .start_ready  (ready3),
    .sr_data      (data3),
    .sr_load_shift(ld3),
    .sr_en        (en3),
    .bit_valid    (bv3),
    .bit_index    (idx3),
    .frame_done   (done3),
    .busy         (busy3)
`ifdef SERIALIZE_CTRL_PARITY_EN
    ,
    .parity_bit   (par3)
`endif
  );

`ifndef SERIALIZE_CTRL_PARITY_EN
  assign par1 = 1'b0;
  assign par3 = 1'b0;
`endif

  // Model: t = cycles since acceptance (0 = idle); outputs derive from the frame timeline.
  int           t1 = 0, t3 = 0;
  logic [W-1:0] mdat1 = '0, mdat3 = '0;

  function automatic int last_t(input int d);
    return 2 + W * d + PEXT * d;
  endfunction

  function automatic obs_t model(input int t, input int d, input logic [W-1:0] dat);
    obs_t o;
    int   k;
    o = '0;
    if (t == 0) begin
      o.ready = 1'b1;
    end else begin
      o.busy = 1'b1;
      if (t == 1) begin
        o.en = 1'b1;
      end else if (t <= 1 + W * d) begin
        k       = (t - 2) / d;
        o.ld_sh = 1'b1;
        o.bv    = 1'b1;
        o.idx   = 4'(k);
        o.en    = ((t - 2) % d == d - 1) && (k < W - 1);
      end else if (t < last_t(d)) begin
        o.bv  = 1'b1;
        o.idx = 4'(W);
        o.par = ^dat;
      end else begin
        o.done = 1'b1;
      end
    end
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1 = 0; t3 = 0; mdat1 = '0; mdat3 = '0;
    end else begin
      if (t1 == 0) begin
        if (start_valid) begin t1 = 1; mdat1 = start_data; end
      end else if (t1 == last_t(1)) t1 = 0;
      else t1 = t1 + 1;
      if (t3 == 0) begin
        if (start_valid) begin t3 = 1; mdat3 = start_data; end
      end else if (t3 == last_t(3)) t3 = 0;
      else t3 = t3 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic compare();
    obs_t o1, o3;
    o1 = '{ready1, ld1, en1, bv1, idx1, done1, busy1, par1};
    o3 = '{ready3, ld3, en3, bv3, idx3, done3, busy3, par3};
    check("div1_ctl",  32'(o1),    32'(model(t1, 1, mdat1)));
    check("div1_data", 32'(data1), 32'(mdat1));
    check("div3_ctl",  32'(o3),    32'(model(t3, 3, mdat3)));
    check("div3_data", 32'(data3), 32'(mdat3));
  endtask

  task automatic step();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_t1(input int target, input int budget);
    int n = 0;
    while (t1 != target && n < budget) begin
      step();
      n++;
    end
    check("wait_t1", 32'(t1), 32'(target));
  endtask

  task automatic frame(input logic [W-1:0] word);
    start_valid = 1'b1;
    start_data  = word;
    step();
    start_valid = 1'b0;
    repeat (20) step();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    compare();
    rst_n = 1'b1;
    step();

    frame(4'b1011);
    frame(4'b0111);

    // Back-to-back: hold valid with 0xA, then 0x5 until the second acceptance.
    start_valid = 1'b1;
    start_data  = 4'hA;
    wait_t1(1, 5);
    start_data  = 4'h5;
    wait_t1(0, 30);
    wait_t1(1, 5);
    start_valid = 1'b0;
    repeat (20) step();

    // Request during SHIFT must be ignored.
    start_valid = 1'b1;
    start_data  = 4'h3;
    step();
    start_valid = 1'b0;
    wait_t1(3, 10);
    start_valid = 1'b1;
    start_data  = 4'hF;
    step();
    start_valid = 1'b0;
    repeat (20) step();

    // Reset mid-SHIFT at bit 2: outputs return to reset values immediately.
    start_valid = 1'b1;
    start_data  = 4'h6;
    step();
    start_valid = 1'b0;
    wait_t1(4, 10);
    #2 rst_n = 1'b0;
    #1 compare();
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    repeat (5) step();

    for (int i = 0; i < 600; i++) begin
      start_valid = ($urandom_range(0, 3) == 0);
      start_data  = W'($urandom);
      step();
    end
    start_valid = 1'b0;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
